cb_opt_pulse_meas: RTL and testbench
====================================

Name: cb_opt_pulse_meas

Overview:
- Downstream consumer of the filtered photoelectric IO signal (the IO filter output).
- Synchronizes that signal into sys_clk, detects edges, and measures each completed high/low segment width in sys_clk cycles.
- Counts rising edges and buffers {level, width} records in a small FIFO for NIOS II readout.

Parameters:
- WIDTH_W, 24: bit width of the segment width counter and width field of a record.
- FIFO_DEPTH, 16: record FIFO depth; power of two, minimum 2.
- TIMEOUT_CYC, 24'd10_000_000: stuck-level timeout in sys_clk cycles; used only with OPT_TIMEOUT_EN.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- filter_opt_i  input  1  filtered photoelectric level.
- meas_en  input  1  measurement enable, level.
- rd_en  input  1  FIFO pop request, one cycle per record.
- rd_data  output  WIDTH_W+1  record: [WIDTH_W]=level of ended segment, [WIDTH_W-1:0]=width.
- rd_valid  output  1  rd_data valid; one-cycle pulse.
- fifo_empty  output  1  FIFO holds no records.
- fifo_cnt  output  clog2(FIFO_DEPTH)+1  number of stored records.
- rise_cnt  output  32  rising-edge count.
- ovf_flag  output  1  sticky: a record was dropped because the FIFO was full.
- ovf_clr  input  1  clears ovf_flag.
- timeout_flag  output  1  sticky stuck-level flag; only driven with OPT_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0 except fifo_empty=1. Internal: FSM=IDLE, FIFO pointers=0, width_cnt=0, sync regs=0.
- Synchronizer: 2-flop chain sync1 -> sync2, then prev <= sync2.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
  - Edge pulse appears 3 sys_clk cycles after filter_opt_i changes.
- FSM states:
  - IDLE: width_cnt held. Goes to ARM on meas_en=1; on that transition rise_cnt is cleared to 0.
  - ARM: waits for the first edge. That edge sets width_cnt<=1 and moves to MEAS. No record is pushed, because the first segment is incomplete.
  - MEAS: on each edge, push record {prev, width_cnt} and set width_cnt<=1. Otherwise width_cnt <= width_cnt+1, saturating at all ones (no wrap).
  - Any state with meas_en=0: return to IDLE next cycle. FIFO contents, rise_cnt and flags are retained.
- rise_cnt increments on every rise while in ARM or MEAS. It wraps 0xFFFF_FFFF -> 0.
- Width semantics: a level stable for N sys_clk cycles at sync2 yields a recorded width of N.
- FIFO push is accepted if not full, or if full with a simultaneous pop (rd_en=1) in the same cycle.
  - Otherwise the record is dropped and ovf_flag<=1.
  - If ovf_clr and a drop occur in the same cycle, the flag ends up set (drop wins).
- FIFO pop: rd_en=1 with fifo_empty=0 gives rd_data registered and rd_valid=1 on the next cycle.
  - rd_en while empty is ignored: rd_valid stays 0 and rd_data holds its last value.
- Simultaneous push and pop on an empty FIFO: the pop is ignored and the push is stored.
- fifo_cnt and fifo_empty update in the same cycle as the pointer change.
- Reset asserted mid-operation: everything returns to reset values immediately, and stored records are lost.

Optional Feature:
- Macro OPT_TIMEOUT_EN.
- Defined:
  - In MEAS, when width_cnt reaches TIMEOUT_CYC without an edge, timeout_flag<=1.
  - The flag clears on the next edge or on a meas_en 0->1 transition; measurement continues.
- Undefined: timeout_flag is tied 0, no compare logic is built, and TIMEOUT_CYC is unused.

Test Plan:
- Latency: meas_en=1, filter_opt_i 0->1 at cycle T -> rise at T+3, FSM enters MEAS, rise_cnt=1, no record pushed.
- Width: after arming, hold filter_opt_i high 100 cycles, then low -> one record {1, 100}. Pop -> rd_valid 1 cycle later with rd_data={1,24'd100}, fifo_empty=1.
- Overflow: FIFO_DEPTH=16, generate 18 completed segments without reads -> fifo_cnt=16, ovf_flag=1, the first 16 records intact. ovf_clr -> flag 0.
- Full with simultaneous push+pop: FIFO full, rd_en coincident with an edge -> fifo_cnt stays 16, ovf_flag stays 0, oldest record read out.
- Saturation/timeout: WIDTH_W=8, high for 300 cycles -> record width 255. With OPT_TIMEOUT_EN and TIMEOUT_CYC=50, timeout_flag=1 at width_cnt=50 and clears at the next edge.
- Reset mid-op: assert rst with 5 records stored and the FSM in MEAS -> fifo_empty=1, rise_cnt=0, FSM=IDLE. After release, meas_en must re-arm before any record is produced.

Source files
------------

// File: rtl/cb_opt_pulse_meas.sv
// ---------------------------------------------------------------------------
// cb_opt_pulse_meas
// Measures the high/low segment widths of the filtered photoelectric signal.
// The level is synchronized into sys_clk, edges are detected, and every
// completed segment is stored as a {level, width} record in a small FIFO
// for software readout. Rising edges are counted while measuring.
//
// Optional build macro: OPT_TIMEOUT_EN
//   defined   -> timeout_flag goes high when a level is held for TIMEOUT_CYC
//                cycles while measuring; cleared by the next edge or re-arm.
//   undefined -> timeout_flag is tied low and no compare logic is built.
//
// Ports
//   sys_clk       system clock, rising edge
//   rst           asynchronous active-high reset
//   filter_opt_i  filtered photoelectric level (asynchronous to sys_clk)
//   meas_en       measurement enable (level)
//   rd_en         FIFO pop request, one cycle per record
//   rd_data       popped record: [WIDTH_W] = level, [WIDTH_W-1:0] = width
//   rd_valid      one-cycle pulse, rd_data valid
//   fifo_empty    FIFO holds no records
//   fifo_cnt      number of stored records
//   rise_cnt      rising-edge count since the last arm
//   ovf_flag      sticky, a record was dropped on a full FIFO
//   ovf_clr       clears ovf_flag
//   timeout_flag  sticky stuck-level flag (OPT_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module cb_opt_pulse_meas #(
    parameter int unsigned WIDTH_W     = 24,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          filter_opt_i,
    input  logic                          meas_en,
    input  logic                          rd_en,
    output logic [WIDTH_W:0]              rd_data,
    output logic                          rd_valid,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic [31:0]                   rise_cnt,
    output logic                          ovf_flag,
    input  logic                          ovf_clr,
    output logic                          timeout_flag
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = WIDTH_W + 1;
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

    // Elaboration-time parameter sanity
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC == 0) begin : g_bad_param
        $error("cb_opt_pulse_meas: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYC nonzero");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;
    logic fall;
    logic any_edge;

    logic arm;
    logic active;
    logic first_edge;
    logic push_req;
    logic meas_run;

    logic [WIDTH_W-1:0] width_cnt;

    logic [RW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_d;
    logic [RW-1:0] rec;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= filter_opt_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise     = sync2 & ~prev;
    assign fall     = ~sync2 & prev;
    assign any_edge = rise | fall;

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control strobes; meas_en low overrides everything
    always_comb begin
        state_d    = state_q;
        arm        = 1'b0;
        active     = 1'b0;
        first_edge = 1'b0;
        push_req   = 1'b0;
        meas_run   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (meas_en) begin
                    state_d = ST_ARM;
                    arm     = 1'b1;
                end
            end
            ST_ARM: begin
                if (!meas_en) begin
                    state_d = ST_IDLE;
                end else begin
                    active = 1'b1;
                    if (any_edge) begin
                        state_d    = ST_MEAS;
                        first_edge = 1'b1;
                    end
                end
            end
            ST_MEAS: begin
                if (!meas_en) begin
                    state_d = ST_IDLE;
                end else begin
                    active = 1'b1;
                    if (any_edge) begin
                        push_req = 1'b1;
                    end else begin
                        meas_run = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Segment width counter, saturating
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            width_cnt <= '0;
        end else if (first_edge || push_req) begin
            width_cnt <= WIDTH_W'(1);
        end else if (meas_run && width_cnt != WIDTH_MAX) begin
            width_cnt <= width_cnt + WIDTH_W'(1);
        end
    end

    // Rising-edge counter, cleared on arm
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rise_cnt <= '0;
        end else if (arm) begin
            rise_cnt <= '0;
        end else if (active && rise) begin
            rise_cnt <= rise_cnt + 32'd1;
        end
    end

    // FIFO control; a full FIFO still accepts a push when a pop frees a slot
    assign rec  = {prev, width_cnt};
    assign full = (fifo_cnt == CW'(FIFO_DEPTH));
    assign pop  = rd_en & ~fifo_empty;
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    always_comb begin
        cnt_d = fifo_cnt;
        if (push && !pop) begin
            cnt_d = fifo_cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_d = fifo_cnt - CW'(1);
        end
    end

    // Record storage, no reset needed
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= rec;
        end
    end

    // Pointers, occupancy, read port and overflow flag
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            fifo_empty <= 1'b1;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_valid   <= pop;
            fifo_cnt   <= cnt_d;
            fifo_empty <= (cnt_d == '0);
            if (drop) begin
                ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                ovf_flag <= 1'b0;
            end
        end
    end

`ifdef OPT_TIMEOUT_EN
    // Stuck-level detection while measuring
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            timeout_flag <= 1'b0;
        end else if (arm || (active && any_edge)) begin
            timeout_flag <= 1'b0;
        end else if (meas_run && width_cnt == WIDTH_W'(TIMEOUT_CYC)) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_cb_opt_pulse_meas.sv
// ---------------------------------------------------------------------------
// Testbench for cb_opt_pulse_meas (WIDTH_W=8, FIFO_DEPTH=16, TIMEOUT_CYC=50).
// A timestamp-based reference model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_cb_opt_pulse_meas;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TO    = 50;
    localparam int unsigned CW    = 5;
    localparam longint      MAXW  = 255;

    logic          sys_clk      = 1'b0;
    logic          rst          = 1'b0;
    logic          filter_opt_i = 1'b0;
    logic          meas_en      = 1'b0;
    logic          rd_en        = 1'b0;
    logic          ovf_clr      = 1'b0;
    logic [W:0]    rd_data;
    logic          rd_valid;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [31:0]   rise_cnt;
    logic          ovf_flag;
    logic          timeout_flag;

    int checks = 0;
    int errors = 0;

    cb_opt_pulse_meas #(
        .WIDTH_W     (W),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .filter_opt_i (filter_opt_i),
        .meas_en      (meas_en),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_empty   (fifo_empty),
        .fifo_cnt     (fifo_cnt),
        .rise_cnt     (rise_cnt),
        .ovf_flag     (ovf_flag),
        .ovf_clr      (ovf_clr),
        .timeout_flag (timeout_flag)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state
    bit          lvl_hist [3];   // input samples: [0] newest
    bit          en_prev;
    bit          started;
    longint      cyc;
    longint      last_e;
    logic [W:0]  q [$];
    logic [W:0]  exp_rd_data;
    bit          exp_rd_valid;
    int unsigned exp_rise;
    bit          exp_ovf;
    bit          to_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) lvl_hist[i] = 1'b0;
        en_prev      = 1'b0;
        started      = 1'b0;
        cyc          = 0;
        last_e       = 0;
        q.delete();
        exp_rd_data  = '0;
        exp_rd_valid = 1'b0;
        exp_rise     = 0;
        exp_ovf      = 1'b0;
        to_flag      = 1'b0;
    endtask

    // Predicts the effect of the coming clock edge with the current inputs.
    // The synchronized level seen at edge k is the input sampled at edge k-2.
    task automatic model_step();
        bit         lvl_now;
        bit         lvl_old;
        bit         push_req;
        bit         pop;
        bit         drop;
        int         n;
        longint     d;
        logic [W:0] rec;
        cyc++;
        lvl_now  = lvl_hist[1];
        lvl_old  = lvl_hist[2];
        push_req = 1'b0;
        drop     = 1'b0;
        rec      = '0;
        if (meas_en && !en_prev) begin
            exp_rise = 0;
            started  = 1'b0;
            to_flag  = 1'b0;
        end else if (meas_en) begin
            if (lvl_now != lvl_old) begin
                if (lvl_now) exp_rise++;
                if (started) begin
                    d = cyc - last_e;
                    if (d > MAXW) d = MAXW;
                    rec      = {lvl_old, W'(d)};
                    push_req = 1'b1;
                end
                started = 1'b1;
                last_e  = cyc;
                to_flag = 1'b0;
            end else if (started && (cyc - last_e) == longint'(TO)) begin
                to_flag = 1'b1;
            end
        end
        en_prev     = meas_en;
        lvl_hist[2] = lvl_hist[1];
        lvl_hist[1] = lvl_hist[0];
        lvl_hist[0] = filter_opt_i;

        n   = q.size();
        pop = rd_en && (n > 0);
        exp_rd_valid = pop;
        if (pop) exp_rd_data = q.pop_front();
        if (push_req) begin
            if (n < int'(DEPTH) || pop) q.push_back(rec);
            else drop = 1'b1;
        end
        if (drop) exp_ovf = 1'b1;
        else if (ovf_clr) exp_ovf = 1'b0;
    endtask

    task automatic check_all();
        bit exp_to;
`ifdef OPT_TIMEOUT_EN
        exp_to = to_flag;
`else
        exp_to = 1'b0;
`endif
        chk("rd_valid",     32'(rd_valid),     32'(exp_rd_valid));
        chk("rd_data",      32'(rd_data),      32'(exp_rd_data));
        chk("fifo_cnt",     32'(fifo_cnt),     32'(q.size()));
        chk("fifo_empty",   32'(fifo_empty),   32'(q.size() == 0));
        chk("rise_cnt",     rise_cnt,          exp_rise);
        chk("ovf_flag",     32'(ovf_flag),     32'(exp_ovf));
        chk("timeout_flag", 32'(timeout_flag), 32'(exp_to));
    endtask

    // One clock: inputs already driven at the falling edge
    task automatic tick();
        model_step();
        @(negedge sys_clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset is asynchronous: outputs must be at reset values right away
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge sys_clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int seg_left;
        int off_left;
        int guard;
        @(negedge sys_clk);
        do_reset();
        chk("reset_empty", 32'(fifo_empty), 32'd1);
        chk("reset_cnt",   32'(fifo_cnt),   32'd0);

        // Latency and a 100-cycle high segment
        meas_en = 1'b1;
        ticks(4);
        filter_opt_i = 1'b1;
        ticks(2);
        chk("lat_pre_rise", rise_cnt, 32'd0);
        tick();
        chk("lat_rise", rise_cnt, 32'd1);
        chk("lat_no_record", 32'(fifo_cnt), 32'd0);
        ticks(97);
        filter_opt_i = 1'b0;
        ticks(5);
        chk("w100_cnt", 32'(fifo_cnt), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("w100_valid", 32'(rd_valid), 32'd1);
        chk("w100_data",  32'(rd_data),  32'({1'b1, 8'd100}));
        chk("w100_empty", 32'(fifo_empty), 32'd1);
        tick();
        chk("w100_pulse", 32'(rd_valid), 32'd0);

        // Overflow: 18 completed segments with no reads
        for (int s = 0; s < 18; s++) begin
            filter_opt_i = ~filter_opt_i;
            ticks($urandom_range(2, 20));
        end
        ticks(3);
        chk("ovf_cnt",  32'(fifo_cnt), 32'd16);
        chk("ovf_flag_set", 32'(ovf_flag), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_flag_clr", 32'(ovf_flag), 32'd0);

        // Full FIFO, pop coincident with a push
        filter_opt_i = ~filter_opt_i;
        ticks(2);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("full_pp_cnt",   32'(fifo_cnt), 32'd16);
        chk("full_pp_ovf",   32'(ovf_flag), 32'd0);
        chk("full_pp_valid", 32'(rd_valid), 32'd1);
        rd_en = 1'b1;
        ticks(18);
        rd_en = 1'b0;
        chk("drain_empty", 32'(fifo_empty), 32'd1);

        // Saturation and stuck-level timeout
        filter_opt_i = ~filter_opt_i;
        ticks(100);
`ifdef OPT_TIMEOUT_EN
        chk("timeout_set", 32'(timeout_flag), 32'd1);
`endif
        ticks(200);
        filter_opt_i = ~filter_opt_i;
        ticks(4);
`ifdef OPT_TIMEOUT_EN
        chk("timeout_clr", 32'(timeout_flag), 32'd0);
`endif
        rd_en = 1'b1;
        ticks(2);
        rd_en = 1'b0;
        chk("sat_width", 32'(rd_data[W-1:0]), 32'd255);

        // Randomized operation
        seg_left = 0;
        off_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (seg_left == 0) begin
                filter_opt_i = ~filter_opt_i;
                seg_left = $urandom_range(1, 70);
            end
            seg_left--;
            if (c < 1500) rd_en = ($urandom_range(0, 49) == 0);
            else          rd_en = ($urandom_range(0, 9) < 3);
            ovf_clr = ($urandom_range(0, 49) == 0);
            if (off_left > 0) begin
                meas_en = 1'b0;
                off_left--;
            end else begin
                meas_en = 1'b1;
                if ($urandom_range(0, 199) == 0) off_left = $urandom_range(1, 10);
            end
            tick();
        end
        ovf_clr = 1'b0;
        meas_en = 1'b1;

        // Reset with records stored while measuring
        rd_en = 1'b1;
        ticks(20);
        rd_en = 1'b0;
        guard = 0;
        while (q.size() < 5 && guard < 60) begin
            filter_opt_i = ~filter_opt_i;
            ticks(5);
            guard++;
        end
        chk("pre_rst_cnt", 32'(fifo_cnt), 32'd5);
        meas_en = 1'b0;
        do_reset();
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_rise",  rise_cnt,        32'd0);
        for (int s = 0; s < 4; s++) begin
            filter_opt_i = ~filter_opt_i;
            ticks(6);
        end
        chk("noarm_cnt",  32'(fifo_cnt), 32'd0);
        chk("noarm_rise", rise_cnt,      32'd0);
        meas_en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            filter_opt_i = ~filter_opt_i;
            ticks(7);
        end
        chk("rearm_cnt", 32'(fifo_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
